// File: rtl/hci_outstanding_sram_target_pkg.sv
// Shared types for the HCI-Outstanding SRAM responder: status flags exported to the cluster.
package hci_outstanding_sram_target_pkg;

    localparam int unsigned FLAGS_CNT_W = 8;

    typedef struct packed {
        logic [FLAGS_CNT_W-1:0] cnt;
        logic                   idle;
    } hci_outstanding_target_flags_t;

endpackage

// File: rtl/hci_outstanding_sram_target_if.sv
// Decoupled request/response channel pair of the HCI-Outstanding protocol.
interface hci_outstanding_sram_target_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32,
    parameter int unsigned UW = 1,
    parameter int unsigned IW = 1
);
    logic            req_valid;
    logic            req_ready;
    logic [AW-1:0]   req_add;
    logic            req_wen;
    logic [DW/8-1:0] req_be;
    logic [DW-1:0]   req_data;
    logic [UW-1:0]   req_user;
    logic [IW-1:0]   req_id;

    logic            resp_valid;
    logic            resp_ready;
    logic [DW-1:0]   resp_data;
    logic [UW-1:0]   resp_user;
    logic [IW-1:0]   resp_id;

    modport master (
        output req_valid, req_add, req_wen, req_be, req_data, req_user, req_id, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_user, resp_id
    );

    modport slave (
        input  req_valid, req_add, req_wen, req_be, req_data, req_user, req_id, resp_ready,
        output req_ready, resp_valid, resp_data, resp_user, resp_id
    );
endinterface

// File: rtl/hci_outstanding_sram_target_fifo.sv
// Registered response queue (no fall-through); depth need not be a power of two.
module hci_outstanding_sram_target_fifo #(
    parameter int unsigned DATA_WIDTH = 34,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  empty
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [DATA_WIDTH-1:0] storage [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  full, push_en, pop_en;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign push_en  = push & ~full;
    assign pop_en   = pop & ~empty;
    assign pop_data = storage[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= next_ptr(wr_ptr);
            if (pop_en)  rd_ptr <= next_ptr(rd_ptr);
            if (push_en && !pop_en)      count <= count + CW'(1);
            else if (!push_en && pop_en) count <= count - CW'(1);
        end
    end

    // NOTE: payload storage has no reset; validity is tracked solely by count, so this maps to plain RAM/flops.
    always_ff @(posedge clk_i) begin
        if (push_en) storage[wr_ptr] <= push_data;
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && full));
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop && empty));
endmodule

// File: rtl/hci_outstanding_sram_target.sv
// HCI-Outstanding responder in front of a fixed-latency SRAM: one in-order response per accepted request.
module hci_outstanding_sram_target
    import hci_outstanding_sram_target_pkg::*;
#(
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 32,
    parameter int unsigned UW          = 1,
    parameter int unsigned IW          = 1,
    parameter int unsigned MEM_AW      = 10,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned RESP_DEPTH  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          enable_i,
    hci_outstanding_sram_target_if.slave  tcdm,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [MEM_AW-1:0]             mem_addr_o,
    output logic [DW/8-1:0]               mem_be_o,
    output logic [DW-1:0]                 mem_wdata_o,
    input  logic [DW-1:0]                 mem_rdata_i,
    output hci_outstanding_target_flags_t flags_o
);
    localparam int unsigned OFFS = $clog2(DW / 8);
    localparam int unsigned CW   = $clog2(RESP_DEPTH + 1);
    localparam int unsigned FW   = DW + UW + IW;

    if (MEM_LATENCY < 1)  begin : g_bad_latency $error("MEM_LATENCY must be >= 1"); end
    if (RESP_DEPTH < 1)   begin : g_bad_depth   $error("RESP_DEPTH must be >= 1"); end
    if (DW % 8 != 0)      begin : g_bad_dw      $error("DW must be a multiple of 8"); end

    typedef struct packed {
        logic          valid;
        logic          wen;
        logic [UW-1:0] user;
        logic [IW-1:0] id;
    } tag_t;

    logic          hs_req, hs_resp;
    logic [CW-1:0] cnt;
    tag_t          pipe [MEM_LATENCY];
    tag_t          pipe_out;
    logic [FW-1:0] fifo_wdata, fifo_rdata;
    logic          fifo_empty;
    logic          unused_addr;

    // Credits cover both the tag pipe and the queue, so a push can never meet a full FIFO.
    assign tcdm.req_ready = enable_i & (cnt < CW'(RESP_DEPTH));
    assign hs_req         = tcdm.req_valid & tcdm.req_ready;
    assign hs_resp        = tcdm.resp_valid & tcdm.resp_ready;

    assign mem_req_o   = hs_req;
    assign mem_we_o    = hs_req & ~tcdm.req_wen;
    assign mem_addr_o  = hs_req ? tcdm.req_add[OFFS +: MEM_AW] : '0;
    assign mem_be_o    = hs_req ? tcdm.req_be : '0;
    assign mem_wdata_o = hs_req ? tcdm.req_data : '0;
    assign unused_addr = ^tcdm.req_add;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MEM_LATENCY; i++) pipe[i] <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < MEM_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: hs_req, wen: tcdm.req_wen, user: tcdm.req_user, id: tcdm.req_id};
            for (int i = 1; i < MEM_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign pipe_out   = pipe[MEM_LATENCY-1];
    assign fifo_wdata = {pipe_out.wen ? mem_rdata_i : '0, pipe_out.user, pipe_out.id};

    hci_outstanding_sram_target_fifo #(
        .DATA_WIDTH (FW),
        .FIFO_DEPTH (RESP_DEPTH)
    ) i_resp_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .push      (pipe_out.valid),
        .push_data (fifo_wdata),
        .pop       (hs_resp),
        .pop_data  (fifo_rdata),
        .empty     (fifo_empty)
    );

    assign tcdm.resp_valid = ~fifo_empty;
    assign {tcdm.resp_data, tcdm.resp_user, tcdm.resp_id} = fifo_rdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
        end else if (clear_i) begin
            cnt <= '0;
        end else if (hs_req && !hs_resp) begin
            cnt <= cnt + CW'(1);
        end else if (!hs_req && hs_resp) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign flags_o.cnt  = FLAGS_CNT_W'(cnt);
    assign flags_o.idle = (cnt == '0);
endmodule

// File: tb/tb_hci_outstanding_sram_target.sv
// Self-checking bench: directed tables, multi-cycle corner sequences and randomized traffic vs a queue model.
module tb_hci_outstanding_sram_target;
    import hci_outstanding_sram_target_pkg::*;

    localparam int DW = 32, AW = 32, UW = 4, IW = 8, MEM_AW = 10, LAT = 1, DEPTH = 4;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic clear_i, enable_i;
    logic mem_req, mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [3:0] mem_be;
    logic [31:0] mem_wdata, mem_rdata;
    hci_outstanding_target_flags_t flags;

    hci_outstanding_sram_target_if #(.DW(DW), .AW(AW), .UW(UW), .IW(IW)) tcdm ();

    hci_outstanding_sram_target #(
        .DW(DW), .AW(AW), .UW(UW), .IW(IW), .MEM_AW(MEM_AW), .MEM_LATENCY(LAT), .RESP_DEPTH(DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .enable_i    (enable_i),
        .tcdm        (tcdm),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_be_o    (mem_be),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .flags_o     (flags)
    );

    always #5 clk_i = ~clk_i;

    // SRAM macro with one cycle read latency
    logic [31:0] sram [1024];
    always @(posedge clk_i) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    typedef struct {
        logic [31:0] data;
        logic [7:0]  id;
        logic [3:0]  user;
        int          cyc;
    } exp_t;

    typedef struct {
        bit          rd;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [7:0]  id;
        logic [31:0] exp;
    } vec_t;

    exp_t        exp_q[$];
    logic [31:0] refmem [1024];
    logic [31:0] got_data_q[$];
    logic [7:0]  got_id_q[$];
    int          got_cyc_q[$];
    int          n_checks = 0, n_pass = 0;
    int          cyc = 0, n_acc = 0, n_resp = 0;
    bit          last_acc;
    vec_t        vecs[8];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic drive(input bit v, input bit rd, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d, input logic [7:0] id);
        tcdm.req_valid = v;
        tcdm.req_wen   = rd;
        tcdm.req_add   = a;
        tcdm.req_be    = be;
        tcdm.req_data  = d;
        tcdm.req_id    = id;
        tcdm.req_user  = id[3:0] ^ 4'h5;
    endtask

    // One cycle: observe at the falling edge, update the model, return just after the rising edge.
    task automatic tick();
        bit acc, rsp, exp_valid;
        exp_t e;
        logic [9:0] w;
        @(negedge clk_i);
        check("cnt", flags.cnt, exp_q.size());
        check("idle", flags.idle, exp_q.size() == 0);
        check("req_ready", tcdm.req_ready, enable_i && exp_q.size() < DEPTH);
        exp_valid = exp_q.size() > 0 && exp_q[0].cyc + LAT + 1 <= cyc;
        check("resp_valid", tcdm.resp_valid, exp_valid);
        acc = tcdm.req_valid && tcdm.req_ready;
        rsp = tcdm.resp_valid && tcdm.resp_ready;
        check("mem_req", mem_req, acc);
        w = tcdm.req_add[11:2];
        if (acc) begin
            check("mem_addr", mem_addr, w);
            check("mem_we", mem_we, !tcdm.req_wen);
            if (!tcdm.req_wen) begin
                check("mem_be", mem_be, tcdm.req_be);
                check("mem_wdata", mem_wdata, tcdm.req_data);
            end
        end
        if (rsp && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("resp_data", tcdm.resp_data, e.data);
            check("resp_id", tcdm.resp_id, e.id);
            check("resp_user", tcdm.resp_user, e.user);
            got_data_q.push_back(tcdm.resp_data);
            got_id_q.push_back(tcdm.resp_id);
            got_cyc_q.push_back(cyc);
            n_resp++;
        end
        if (acc) begin
            n_acc++;
            e.cyc  = cyc;
            e.id   = tcdm.req_id;
            e.user = tcdm.req_user;
            if (tcdm.req_wen) begin
                e.data = refmem[w];
            end else begin
                e.data = '0;
                for (int b = 0; b < 4; b++) if (tcdm.req_be[b]) refmem[w][8*b +: 8] = tcdm.req_data[8*b +: 8];
            end
        end
        last_acc = acc;
        if (clear_i) exp_q.delete();
        else if (acc) exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic drain(input string name);
        drive(0, 1, 0, 0, 0, 0);
        tcdm.resp_ready = 1'b1;
        for (int i = 0; i < 100 && (exp_q.size() > 0 || tcdm.resp_valid); i++) tick();
        check(name, exp_q.size(), 0);
    endtask

    task automatic reset_logs();
        got_data_q.delete();
        got_id_q.delete();
        got_cyc_q.delete();
        n_acc  = 0;
        n_resp = 0;
    endtask

    initial begin
        int first_cyc;
        clear_i = 1'b0;
        enable_i = 1'b1;
        tcdm.resp_ready = 1'b1;
        drive(0, 1, 0, 0, 0, 0);

        // reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_resp_valid", tcdm.resp_valid, 0);
        check("rst_req_ready", tcdm.req_ready, 1);
        check("rst_idle", flags.idle, 1);
        check("rst_cnt", flags.cnt, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // directed table: RAW, partial write, address aliasing, top word
        vecs[0] = '{0, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 8'd1, 32'h0};
        vecs[1] = '{1, 32'h0000_0010, 4'h0, 32'h0,         8'd2, 32'hDEAD_BEEF};
        vecs[2] = '{0, 32'h0000_0020, 4'hF, 32'h1122_3344, 8'd3, 32'h0};
        vecs[3] = '{0, 32'h0000_0020, 4'h2, 32'hAABB_CCDD, 8'd4, 32'h0};
        vecs[4] = '{1, 32'h0000_0020, 4'h0, 32'h0,         8'd5, 32'h1122_CC44};
        vecs[5] = '{1, 32'h0000_1010, 4'h0, 32'h0,         8'd6, 32'hDEAD_BEEF};
        vecs[6] = '{0, 32'h0000_0FFC, 4'hF, 32'h0102_0304, 8'd7, 32'h0};
        vecs[7] = '{1, 32'hFFFF_FFFC, 4'h0, 32'h0,         8'd8, 32'h0102_0304};
        reset_logs();
        first_cyc = cyc;
        for (int i = 0; i < 8; i++) begin
            drive(1, vecs[i].rd, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].id);
            tick();
        end
        drain("vec_drain");
        check("vec_count", got_data_q.size(), 8);
        if (got_cyc_q.size() > 0) check("vec_latency", got_cyc_q[0] - first_cyc, LAT + 1);
        for (int i = 0; i < 8 && i < got_data_q.size(); i++) begin
            check("vec_data", got_data_q[i], vecs[i].exp);
            check("vec_id", got_id_q[i], vecs[i].id);
        end

        // prefill words 0..15 so every later read returns known data
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 32'(i * 4), 4'hF, $urandom, 8'(i));
            tick();
        end
        drain("prefill_drain");

        // backpressure: six reads against a stalled response port
        reset_logs();
        tcdm.resp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 32'(4 * (i % 16)), 0, 0, 8'(8'h40 + i));
            tick();
        end
        check("bp_accepted", n_acc, 4);
        check("bp_cnt", flags.cnt, 4);
        check("bp_req_ready", tcdm.req_ready, 0);
        drain("bp_drain");
        check("bp_resp_count", n_resp, 4);
        for (int i = 0; i < 4 && i < got_id_q.size(); i++) check("bp_order", got_id_q[i], 8'h40 + i);

        // simultaneous response pop and new request at full credit
        tcdm.resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'(4 * i), 0, 0, 8'(8'h50 + i));
            tick();
        end
        check("sim_full", flags.cnt, 4);
        tcdm.resp_ready = 1'b1;
        drive(1, 1, 32'h8, 0, 0, 8'h60);
        tick();
        check("sim_no_accept", last_acc, 0);
        tick();
        check("sim_accept", last_acc, 1);
        check("sim_cnt_hold", flags.cnt, 3);
        tcdm.resp_ready = 1'b0;
        drive(1, 1, 32'hC, 0, 0, 8'h61);
        tick();
        check("sim_cnt_refill", flags.cnt, 4);
        drain("sim_drain");

        // streaming: 64 back-to-back reads
        reset_logs();
        for (int i = 0; i < 64; i++) begin
            drive(1, 1, 32'(4 * (i % 16)), 0, 0, 8'(i));
            tick();
        end
        drain("stream_drain");
        check("stream_acc", n_acc, 64);
        check("stream_resp", n_resp, 64);
        for (int i = 0; i < got_id_q.size(); i++) begin
            check("stream_id", got_id_q[i], 8'(i));
            check("stream_rate", got_cyc_q[i] - got_cyc_q[0], i);
        end

        // clear with three outstanding and a write handshaking in the clear cycle
        reset_logs();
        tcdm.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 32'(4 * i), 0, 0, 8'(8'h70 + i));
            tick();
        end
        clear_i = 1'b1;
        drive(1, 0, 32'h30, 4'hF, 32'hCAFE_F00D, 8'h7F);
        tick();
        clear_i = 1'b0;
        drive(0, 1, 0, 0, 0, 0);
        check("clr_resp_valid", tcdm.resp_valid, 0);
        check("clr_cnt", flags.cnt, 0);
        check("clr_idle", flags.idle, 1);
        tcdm.resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("clr_no_stale", n_resp, 0);
        drive(1, 1, 32'h30, 0, 0, 8'h80);
        tick();
        drain("clr_drain");
        if (got_data_q.size() > 0) check("clr_write_landed", got_data_q[0], 32'hCAFE_F00D);

        // enable dropped mid-burst: acceptance stops, pipeline drains
        reset_logs();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 32'(4 * i), 0, 0, 8'(8'h90 + i));
            tick();
        end
        enable_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("en_acc", n_acc, 3);
        check("en_resp", n_resp, 3);
        enable_i = 1'b1;
        drain("en_drain");

        // randomized traffic against the queue model
        for (int i = 0; i < 800; i++) begin
            enable_i        = ($urandom_range(0, 9) != 0);
            clear_i         = ($urandom_range(0, 49) == 0);
            tcdm.resp_ready = ($urandom_range(0, 9) < 6);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                  {$urandom_range(0, 7) == 0 ? 20'(($urandom)) : 20'h0, 6'h0, 4'($urandom_range(0, 15)), 2'b0},
                  4'($urandom), $urandom, 8'($urandom));
            tick();
        end
        clear_i  = 1'b0;
        enable_i = 1'b1;
        drain("rand_drain");

        // asynchronous reset with responses outstanding
        tcdm.resp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 32'(4 * i), 0, 0, 8'(8'hA0 + i));
            tick();
        end
        rst_ni = 1'b0;
        #1;
        check("arst_resp_valid", tcdm.resp_valid, 0);
        check("arst_cnt", flags.cnt, 0);
        check("arst_idle", flags.idle, 1);
        check("arst_mem_req", mem_req, 1);
        exp_q.delete();
        drive(0, 1, 0, 0, 0, 0);
        #1;
        check("arst_mem_quiet", mem_req, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        cyc++;
        reset_logs();
        tcdm.resp_ready = 1'b1;
        drive(1, 1, 32'h10, 0, 0, 8'hB0);
        tick();
        drain("arst_drain");
        check("arst_resp_count", n_resp, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
